// File: rtl/dcache_dm_ctrl_pkg.sv
// Shared sizing and FSM encoding for the direct-mapped data cache.
package dcache_pkg;
  localparam int NUM_LINES  = 32;
  localparam int LINE_BITS  = 256;
  localparam int ADDR_W     = 32;
  localparam int WORD_W     = 32;
  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;
  localparam int IDX_W      = $clog2(NUM_LINES);
  localparam int TAG_W      = ADDR_W - OFFSET_W - IDX_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WBACK = 2'd1,
    ST_ALLOC = 2'd2,
    ST_FILL  = 2'd3
  } state_t;
endpackage

// File: rtl/dcache_dm_ctrl_if.sv
// CPU-side and memory-side signal bundle of the data cache.
interface dcache_dm_ctrl_if;
  import dcache_pkg::*;

  // cpu_req_i is held with its operands until a cycle with cpu_stall_o=0 completes it;
  // mem_req_o is held with its operands until the cycle in which mem_ack_i pulses.
  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [WORD_W-1:0]    cpu_wdata_i;
  logic [WORD_W-1:0]    cpu_rdata_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [LINE_BITS-1:0] mem_wdata_o;
  logic [LINE_BITS-1:0] mem_rdata_i;
  logic                 mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i, mem_rdata_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o
  );
endinterface

// File: rtl/dcache_dm_array.sv
// Tag/valid/dirty/data storage: one write port (line fill or word store), combinational read.
module dcache_dm_array
  import dcache_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_BITS-1:0]  rd_line,
  input  logic                  wr_en,
  input  logic                  wr_fill,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [WORD_SEL_W-1:0] wr_wsel,
  input  logic [WORD_W-1:0]     wr_word,
  input  logic [LINE_BITS-1:0]  wr_line
);
  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_BITS-1:0] data_q [NUM_LINES];

  // A fill leaves the line clean; a word store marks it dirty.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= !wr_fill;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      if (wr_fill) begin
        tag_q[wr_idx]  <= wr_tag;
        data_q[wr_idx] <= wr_line;
      end else begin
        data_q[wr_idx][{wr_wsel, 5'b00000} +: WORD_W] <= wr_word;
      end
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_line  = data_q[rd_idx];
endmodule

// File: rtl/dcache_dm_ctrl.sv
// Direct-mapped write-back/write-allocate data cache for the MEM stage, with its miss FSM.
module dcache_dm_ctrl
  import dcache_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_i,
  dcache_dm_ctrl_if.slave bus,
  output state_t          state_o
);
  logic [TAG_W-1:0]      cpu_tag;
  logic [IDX_W-1:0]      cpu_idx;
  logic [WORD_SEL_W-1:0] cpu_wsel;
  logic                  rd_valid, rd_dirty, hit;
  logic [TAG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0]  rd_line;

  state_t                state_q, state_d;
  logic [TAG_W-1:0]      miss_tag_q;
  logic [IDX_W-1:0]      miss_idx_q;
  logic [LINE_BITS-1:0]  fill_q;
  logic                  mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [LINE_BITS-1:0]  mem_wdata_q, mem_wdata_d;
  logic                  wr_en, wr_fill;
  logic [IDX_W-1:0]      wr_idx;
  logic [TAG_W-1:0]      wr_tag;

  assign cpu_tag  = bus.cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx  = bus.cpu_addr_i[OFFSET_W +: IDX_W];
  assign cpu_wsel = bus.cpu_addr_i[2 +: WORD_SEL_W];

  dcache_dm_array u_array (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .rd_idx   (cpu_idx),
    .rd_valid (rd_valid),
    .rd_dirty (rd_dirty),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (wr_en),
    .wr_fill  (wr_fill),
    .wr_idx   (wr_idx),
    .wr_tag   (wr_tag),
    .wr_wsel  (cpu_wsel),
    .wr_word  (bus.cpu_wdata_i),
    .wr_line  (fill_q)
  );

  assign hit             = bus.cpu_req_i && rd_valid && (rd_tag == cpu_tag);
  assign bus.cpu_stall_o = bus.cpu_req_i && (!hit || (state_q != ST_IDLE));
  assign bus.cpu_rdata_o = hit ? rd_line[{cpu_wsel, 5'b00000} +: WORD_W] : '0;
  assign state_o         = state_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (bus.cpu_req_i && !hit) state_d = (rd_valid && rd_dirty) ? ST_WBACK : ST_ALLOC;
      ST_WBACK: if (bus.mem_ack_i) state_d = ST_ALLOC;
      ST_ALLOC: if (bus.mem_ack_i) state_d = ST_FILL;
      ST_FILL:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory-side values are computed for the next state and registered, so the
  // request rises one cycle after the miss and drops as soon as FILL is entered.
  always_comb begin
    mem_req_d   = (state_d == ST_WBACK) || (state_d == ST_ALLOC);
    mem_we_d    = (state_d == ST_WBACK);
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    wr_en       = 1'b0;
    wr_fill     = 1'b0;
    wr_idx      = cpu_idx;
    wr_tag      = cpu_tag;
    unique case (state_q)
      ST_IDLE: begin
        if (state_d == ST_WBACK) begin
          mem_addr_d  = {rd_tag, cpu_idx, {OFFSET_W{1'b0}}};
          mem_wdata_d = rd_line;
        end else if (state_d == ST_ALLOC) begin
          mem_addr_d  = {cpu_tag, cpu_idx, {OFFSET_W{1'b0}}};
        end
        wr_en = bus.cpu_req_i && bus.cpu_we_i && hit;
      end
      ST_WBACK: begin
        if (state_d == ST_ALLOC) begin
          mem_addr_d  = {miss_tag_q, miss_idx_q, {OFFSET_W{1'b0}}};
          mem_wdata_d = '0;
        end
      end
      ST_FILL: begin
        wr_en   = 1'b1;
        wr_fill = 1'b1;
        wr_idx  = miss_idx_q;
        wr_tag  = miss_tag_q;
      end
      default: ;
    endcase
    if (!mem_req_d) begin
      mem_addr_d  = '0;
      mem_wdata_d = '0;
    end
  end

  // The missing line's tag/index are captured so a dropped request still fills correctly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      miss_tag_q  <= '0;
      miss_idx_q  <= '0;
      fill_q      <= '0;
    end else begin
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (state_q == ST_IDLE && state_d != ST_IDLE) begin
        miss_tag_q <= cpu_tag;
        miss_idx_q <= cpu_idx;
      end
      if (state_q == ST_ALLOC && bus.mem_ack_i) fill_q <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_wdata_o = mem_wdata_q;
endmodule

// File: tb/tb_dcache_dm_ctrl.sv
// Bench for dcache_dm_ctrl: directed scenarios plus random loads/stores against a coherent-memory model.
module tb_dcache_dm_ctrl;
  import dcache_pkg::*;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  dcache_dm_ctrl_if bus();

  dcache_dm_ctrl dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .bus     (bus),
    .state_o (state_dbg)
  );

  // clock/reset
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model: coherent word memory plus per-index line bookkeeping
  logic [31:0]  ref_mem [logic [31:0]];
  logic [255:0] dram    [logic [31:0]];
  bit           m_valid [NUM_LINES];
  bit           m_dirty [NUM_LINES];
  logic [31:0]  m_tag   [NUM_LINES];

  // scoreboard: expected memory transactions {we, line addr} and write-back lines
  logic [32:0]  exp_q[$];
  logic [255:0] exp_line_q[$];

  int lat   = 3;
  int cnt   = 0;
  bit turn  = 0;
  bit noise = 0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  function automatic logic [255:0] line_of(input logic [31:0] base);
    logic [255:0] l;
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = ref_rd(base + 32'(4*w));
    return l;
  endfunction

  function automatic logic [255:0] dram_line(input logic [31:0] base);
    logic [255:0] l;
    if (dram.exists(base)) return dram[base];
    for (int w = 0; w < 8; w++) l[w*32 +: 32] = init_word(base + 32'(4*w));
    return l;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_LINES; i++) begin
      m_valid[i] = 0;
      m_dirty[i] = 0;
      m_tag[i]   = '0;
    end
  endtask

  // memory responder: ack on the lat-th cycle of a request, one idle cycle after every ack
  always @(negedge clk) begin
    if (rst) begin
      cnt = 0;
      turn = 0;
      bus.mem_ack_i = 1'b0;
    end else if (noise) begin
      bus.mem_ack_i   = 1'($urandom_range(0, 1));
      bus.mem_rdata_i = {8{$urandom()}};
    end else begin
      bus.mem_ack_i   = 1'b0;
      bus.mem_rdata_i = {8{$urandom()}};
      if (turn) begin
        turn = 0;
      end else if (bus.mem_req_o) begin
        cnt++;
        if (cnt >= lat) begin
          logic [32:0] e;
          cnt = 0;
          turn = 1;
          bus.mem_ack_i = 1'b1;
          check("mem_pending", 256'(exp_q.size() != 0), 256'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("mem_req", {bus.mem_we_o, bus.mem_addr_o}, e);
          end
          if (bus.mem_we_o) begin
            if (exp_line_q.size() != 0) check("wb_line", bus.mem_wdata_o, exp_line_q.pop_front());
            dram[bus.mem_addr_o] = bus.mem_wdata_o;
          end else begin
            bus.mem_rdata_i = dram_line(bus.mem_addr_o);
          end
        end
      end
    end
  end

  // driver: one CPU access, held until the stall drops; checks stall length and load data
  task automatic access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
    int          idx, stalls, exp_stall;
    logic [31:0] tg, base_v, exp_rd;
    idx = int'((addr >> 5) % NUM_LINES);
    tg  = addr >> (5 + IDX_W);
    if (m_valid[idx] && m_tag[idx] == tg) begin
      exp_stall = 0;
    end else begin
      if (m_valid[idx] && m_dirty[idx]) begin
        base_v = (m_tag[idx] << (5 + IDX_W)) | 32'(idx << 5);
        exp_q.push_back({1'b1, base_v});
        exp_line_q.push_back(line_of(base_v));
        exp_stall = 2*lat + 3;
      end else begin
        exp_stall = lat + 2;
      end
      exp_q.push_back({1'b0, addr & ~32'd31});
      m_valid[idx] = 1;
      m_dirty[idx] = 0;
      m_tag[idx]   = tg;
    end
    exp_rd = ref_rd(addr);
    if (we) begin
      ref_mem[addr] = wdata;
      m_dirty[idx]  = 1;
    end
    @(negedge clk);
    bus.cpu_req_i   = 1'b1;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_wdata_i = wdata;
    stalls = 0;
    #1;
    while (bus.cpu_stall_o && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    check({tag, "_stall"}, 256'(stalls), 256'(exp_stall));
    if (!we) check({tag, "_rdata"}, bus.cpu_rdata_o, exp_rd);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    bus.cpu_req_i  = 1'b0;
    bus.cpu_we_i   = 1'($urandom_range(0, 1));
    bus.cpu_addr_i = $urandom() & ~32'd3;
    #1;
    check({tag, "_stall"}, bus.cpu_stall_o, 1'b0);
    check({tag, "_memreq"}, bus.mem_req_o, 1'b0);
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] t, i, w;
    t = $urandom_range(0, 3);
    i = $urandom_range(0, 3);
    w = $urandom_range(0, 7);
    return (t << (5 + IDX_W)) | (i << 5) | (w << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.mem_ack_i   = 1'b0;
    bus.mem_rdata_i = '0;
    model_reset();

    // reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_stall", bus.cpu_stall_o, 1'b0);
    check("rst_memreq", bus.mem_req_o, 1'b0);
    check("rst_memwe", bus.mem_we_o, 1'b0);
    check("rst_memaddr", bus.mem_addr_o, 32'd0);
    check("rst_memwdata", bus.mem_wdata_o, 256'd0);
    check("rst_rdata", bus.cpu_rdata_o, 32'd0);
    check("rst_state", state_dbg, ST_IDLE);
    rst = 1'b0;

    // directed scenarios at L=3
    lat = 3;
    access(0, 32'h40, 32'h0, "t1_cold_load");
    access(0, 32'h44, 32'h0, "t2_hit_load");
    access(1, 32'h48, 32'hDEAD_BEEF, "t3_store");
    access(0, 32'h48, 32'h0, "t3_reload");
    check("t3_model_word", ref_rd(32'h48), 32'hDEAD_BEEF);
    access(0, 32'h448, 32'h0, "t4_dirty_miss");

    // reset during ALLOC
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = 1'b0;
    bus.cpu_addr_i = 32'h40;
    @(negedge clk);
    @(negedge clk);
    #2;
    check("t5_state_alloc", state_dbg, ST_ALLOC);
    check("t5_req_before", bus.mem_req_o, 1'b1);
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    check("t5_req_async", bus.mem_req_o, 1'b0);
    check("t5_state_idle", state_dbg, ST_IDLE);
    exp_q.delete();
    exp_line_q.delete();
    model_reset();
    @(negedge clk);
    #1;
    rst = 1'b0;
    access(0, 32'h40, 32'h0, "t5_reload_miss");

    // no request with address and ack noise
    noise = 1;
    for (int i = 0; i < 16; i++) idle_cycle("t6_noise");
    noise = 0;
    @(negedge clk);
    access(0, 32'h40, 32'h0, "t6_after_noise");
    access(0, 32'h5C, 32'h0, "t6_after_noise_w7");

    // random traffic
    for (int n = 0; n < 300; n++) begin
      lat = $urandom_range(1, 4);
      if ($urandom_range(0, 9) == 0) idle_cycle("rnd_idle");
      else access(1'($urandom_range(0, 1)), rnd_addr(), $urandom(), "rnd");
    end

    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    repeat (3) @(negedge clk);
    check("exp_q_drained", 256'(exp_q.size()), 256'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
